// File: rtl/reg_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_pkg
// Purpose  : Shared widths, requester indices, issue-state enum and a
//            saturating-increment helper for the register write-back arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package reg_wb_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int CNT_W  = 16;

    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } wb_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_wb_arbiter_wb_arb2.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb2
// Purpose  : Two-way grant logic. Round-robin with a pointer register when
//            REG_WB_RR_EN is defined, otherwise fixed priority REQ1 over REQ0.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb2
    import reg_wb_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] VALID,
    input  logic       FREEZE,
    output logic [1:0] GNT
);

`ifdef REG_WB_RR_EN
    logic r_ptr_q;
    logic w_ptr_d;

    // Pointer only moves when the favoured side actually transfers.
    always_comb begin
        GNT = 2'b00;
        if (!FREEZE) begin
            if (&VALID) begin
                GNT[r_ptr_q] = 1'b1;
            end else begin
                GNT = VALID;
            end
        end
        w_ptr_d = r_ptr_q ^ GNT[r_ptr_q];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr_q <= 1'b0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end
`else
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = CLK ^ RST_N;

    always_comb begin
        GNT = 2'b00;
        if (!FREEZE) begin
            GNT = VALID[REQ_LD] ? 2'b10 : VALID;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_arbiter
// Purpose  : Write-back arbiter/sequencer for the register bank write port.
//            Optional round-robin arbitration via macro REG_WB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_wb_arbiter
    import reg_wb_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FREEZE,
    input  logic              REQ0_VALID,
    input  logic [REG_AW-1:0] REQ0_ADDR,
    input  logic [REG_DW-1:0] REQ0_DATA,
    input  logic              REQ1_VALID,
    input  logic [REG_AW-1:0] REQ1_ADDR,
    input  logic [REG_DW-1:0] REQ1_DATA,
    output logic              REQ0_READY,
    output logic              REQ1_READY,
    output logic [REG_AW-1:0] AW,
    output logic [REG_DW-1:0] DIN,
    output logic              REG_WRITE,
    output logic [CNT_W-1:0]  WR_CNT,
    output logic [CNT_W-1:0]  DROP_CNT
);

    logic [1:0]        w_gnt;
    logic              w_xfer;
    logic [REG_AW-1:0] w_sel_addr;
    logic [REG_DW-1:0] w_sel_data;

    wb_state_e         r_state_q, w_state_d;
    logic [REG_AW-1:0] r_aw_q,    w_aw_d;
    logic [REG_DW-1:0] r_din_q,   w_din_d;
    logic [CNT_W-1:0]  r_wr_q,    w_wr_d;
    logic [CNT_W-1:0]  r_drop_q,  w_drop_d;

    wb_arb2 u_arb (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .VALID  ({REQ1_VALID, REQ0_VALID}),
        .FREEZE (FREEZE),
        .GNT    (w_gnt)
    );

    assign REQ0_READY = w_gnt[REQ_ALU];
    assign REQ1_READY = w_gnt[REQ_LD];
    assign w_xfer     = |w_gnt;
    assign w_sel_addr = w_gnt[REQ_LD] ? REQ1_ADDR : REQ0_ADDR;
    assign w_sel_data = w_gnt[REQ_LD] ? REQ1_DATA : REQ0_DATA;

    // Register 0 is hardwired in the bank, so its writes are counted and dropped.
    always_comb begin
        w_state_d = IDLE;
        w_aw_d    = r_aw_q;
        w_din_d   = r_din_q;
        w_wr_d    = r_wr_q;
        w_drop_d  = r_drop_q;
        if (w_xfer) begin
            if (w_sel_addr != '0) begin
                w_state_d = ISSUE;
                w_aw_d    = w_sel_addr;
                w_din_d   = w_sel_data;
                w_wr_d    = sat_inc(r_wr_q);
            end else begin
                w_drop_d  = sat_inc(r_drop_q);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state_q <= IDLE;
            r_aw_q    <= '0;
            r_din_q   <= '0;
            r_wr_q    <= '0;
            r_drop_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_aw_q    <= w_aw_d;
            r_din_q   <= w_din_d;
            r_wr_q    <= w_wr_d;
            r_drop_q  <= w_drop_d;
        end
    end

    assign AW        = r_aw_q;
    assign DIN       = r_din_q;
    assign REG_WRITE = (r_state_q == ISSUE);
    assign WR_CNT    = r_wr_q;
    assign DROP_CNT  = r_drop_q;

endmodule
`default_nettype wire

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter and sequencer for the 32x32 register bank's single write port. Two producers compete for the port: requester 0 is ALU write-back, requester 1 is load write-back. The block grants at most one producer per cycle and registers the winning address and data. It then drives the bank's AW, DIN and REG_WRITE as a one-cycle write strobe. Writes to register 0 are absorbed without strobing the bank.

## Interface
- REG_AW, 5, register address width (32 registers)
- REG_DW, 32, register data width
- CNT_W, 16, width of the performed-write counter
- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- FREEZE  in  1  pipeline stall; while high, no request is accepted
- REQ0_VALID, REQ1_VALID  in  1  write request pending
- REQ0_ADDR, REQ1_ADDR  in  REG_AW  destination register
- REQ0_DATA, REQ1_DATA  in  REG_DW  write data
- REQ0_READY, REQ1_READY  out  1  request accepted this cycle (combinational)
- AW  out  REG_AW  registered write address to bank
- DIN  out  REG_DW  registered write data to bank
- REG_WRITE  out  1  registered write strobe to bank
- WR_CNT  out  CNT_W  count of strobes issued, saturating
- DROP_CNT  out  CNT_W  count of accepted address-0 requests, saturating

## Operation
- Handshake:
  - A transfer occurs on the rising edge where VALID and READY are both high.
  - A requester holds VALID, ADDR and DATA stable until READY is seen.
- Grant:
  - READY is high for at most one requester per cycle.
  - READY is never high while FREEZE is high or while that requester's VALID is low.
  - With one VALID, that requester is granted.
  - With both VALID, arbitration policy applies (see Configuration).
- Issue stage, on a transfer with ADDR != 0:
  - Next cycle REG_WRITE=1, AW=ADDR, DIN=DATA.
  - WR_CNT increments.
- Issue stage, on a transfer with ADDR == 0:
  - REG_WRITE stays 0.
  - AW and DIN are unchanged.
  - DROP_CNT increments.
- With no transfer, REG_WRITE=0 next cycle; AW and DIN hold their last values.
- Counters saturate at all-ones and never wrap.
- Same-address requests from both producers are serialized in grant order. The later write wins in the bank.
- Issue stage state machine:
  - IDLE to ISSUE on a transfer with nonzero ADDR.
  - ISSUE to ISSUE on a further such transfer.
  - ISSUE to IDLE otherwise.
  - REG_WRITE = (state == ISSUE).

## Timing
- Latency: accept edge to bank strobe is exactly 1 cycle.
- Throughput: one write per cycle, sustained.
- Worst-case wait for a VALID requester, both requesters continuously VALID, FREEZE low:
  - Round-robin: at most 1 cycle.
  - Fixed priority: unbounded.
- FREEZE asserted:
  - READY drops the same cycle (combinational).
  - A strobe already registered still issues on the next cycle.
- Reset values (asynchronous, on RST_N low): AW=0, DIN=0, REG_WRITE=0, WR_CNT=0, DROP_CNT=0, state=IDLE, round-robin pointer favours REQ0.
- Reset mid-operation: a strobe in flight is cancelled. Requests still VALID after RST_N rises are re-arbitrated from the reset pointer.
- The first transfer can occur on the first rising edge with RST_N high.

## Configuration
- REG_WB_RR_EN defined:
  - Two-way round-robin.
  - The pointer toggles to the other requester after each transfer by the currently favoured one.
  - On a tie, the favoured requester wins.
- REG_WB_RR_EN undefined:
  - Fixed priority, REQ1 (load) over REQ0 (ALU).
  - No pointer state is instantiated.

## Structure
- Shared package reg_wb_pkg holds:
  - REG_AW, REG_DW, CNT_W constants.
  - Requester index constants REQ_ALU=0, REQ_LD=1.
  - The issue-state enum (IDLE, ISSUE).
- One sub-module, wb_arb2:
  - Purely the two-way grant logic.
  - Contains the round-robin pointer register under REG_WB_RR_EN.
  - Ports: CLK, RST_N, VALID[1:0], FREEZE, GNT[1:0].
- Top-level contents: handshake, issue register, state machine, counters.

## Test plan
- Single write: REQ0 VALID, ADDR=5, DATA=0xDEADBEEF → REQ0_READY same cycle; next cycle REG_WRITE=1, AW=5, DIN=0xDEADBEEF; WR_CNT=1.
- Tie: both VALID for 4 cycles → round-robin grants REQ0, REQ1, REQ0, REQ1 with 4 strobes; fixed priority grants REQ1 every cycle.
- Address 0: REQ1 ADDR=0 accepted → REG_WRITE stays 0, AW unchanged, DROP_CNT=1, WR_CNT unchanged.
- FREEZE: both VALID, FREEZE high 3 cycles → both READY low and REG_WRITE low after the in-flight strobe; on release, grant resumes per policy.
- Reset mid-op: RST_N low in the cycle after an accept → REG_WRITE never pulses, counters read 0, first post-reset tie goes to REQ0.
- Saturation: preload via 65535 writes, then 2 more → WR_CNT holds 0xFFFF.
